// File: rtl/ha_result_checker_if.sv
// ha_result_checker_if: operand/result bundle between the adder under test and its checker
interface ha_result_checker_if;
  logic start;
  logic in_valid;
  logic a;
  logic b;
  logic sum;
  logic carry;
  modport master (output start, in_valid, a, b, sum, carry);
  modport slave  (input  start, in_valid, a, b, sum, carry);
endinterface

// File: rtl/ha_result_checker.sv
// ha_result_checker: half-adder response monitor; optional coverage bitmap via HA_CHECK_COVERAGE_EN
module ha_result_checker #(
  parameter int LATENCY     = 0,
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ha_result_checker_if.slave   hif,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     vec_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     first_fail_idx,
  output logic [3:0]           cov
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam int D = LATENCY > 0 ? LATENCY : 1;
  localparam logic [CNT_W-1:0] NV = CNT_W'(NUM_VECTORS);
  logic [1:0] state;
  logic [D-1:0] sv, sa, sb;
  logic run, go, live, dv, da, db, cv, bad;
  logic [CNT_W-1:0] vc_n;
  assign run  = state == RUN;
  assign go   = hif.start && !run;
  assign live = run && hif.in_valid;
  assign busy = run;
  assign done = state == DONE;
  // stage storage exists even at LATENCY=0 but is bypassed by the live tap
  assign dv   = LATENCY == 0 ? live  : sv[D-1];
  assign da   = LATENCY == 0 ? hif.a : sa[D-1];
  assign db   = LATENCY == 0 ? hif.b : sb[D-1];
  assign cv   = run && dv;
  assign bad  = {hif.carry, hif.sum} != {da & db, da ^ db};
  assign vc_n = vec_count + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sv <= '0;
      sa <= '0;
      sb <= '0;
    end else if (go) begin
      sv <= '0;
      sa <= '0;
      sb <= '0;
    end else begin
      sv <= (sv << 1) | D'(live);
      sa <= (sa << 1) | D'(hif.a);
      sb <= (sb << 1) | D'(hif.b);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      mismatch       <= 1'b0;
      vec_count      <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
    end else begin
      mismatch <= cv && bad;
      if (go) begin
        state          <= RUN;
        vec_count      <= '0;
        err_count      <= '0;
        first_fail_idx <= '0;
      end else if (cv) begin
        vec_count <= vc_n;
        if (bad && !(&err_count)) err_count <= err_count + 1'b1;
        if (bad && err_count == '0) first_fail_idx <= vc_n;
        if (vc_n == NV) state <= DONE;
      end
    end
`ifdef HA_CHECK_COVERAGE_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cov <= 4'b0000;
    else if (go) cov <= 4'b0000;
    else if (cv) cov[{da, db}] <= 1'b1;
  assign pass = done && err_count == '0 && &cov;
`else
  assign cov  = 4'b0000;
  assign pass = done && err_count == '0;
`endif
endmodule

// File: doc/ha_result_checker.md
# ha_result_checker

Synthesizable self-checking response monitor for the half-adder datapath. It sits at the output end of the adder interface. It captures each operand pair (`a`, `b`) applied to the adder under test and delays it to match the adder's result latency. It then compares the observed `sum`/`carry` against `a^b` / `a&b`, counts vectors and mismatches, and reports pass/fail once a programmed number of vectors has been checked.

## Interface
Parameters:
- `LATENCY`, 0: cycles from operand-valid to result-valid at the adder; legal range 0–7.
- `NUM_VECTORS`, 4: vectors compared per run; legal range 1 to 2^`CNT_W`−1.
- `CNT_W`, 16: width of the vector and error counters.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: pulse that begins a run. Honoured in IDLE and DONE; ignored in RUN.
- `in_valid`, in, 1: `a`/`b` are being applied to the adder this cycle.
- `a`, in, 1: operand a as driven to the adder.
- `b`, in, 1: operand b as driven to the adder.
- `sum`, in, 1: adder sum output.
- `carry`, in, 1: adder carry output.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `pass`, out, 1: valid while `done`; 1 means zero mismatches.
- `mismatch`, out, 1: one-cycle pulse per failing compare.
- `vec_count`, out, `CNT_W`: number of vectors compared in the current run.
- `err_count`, out, `CNT_W`: number of mismatches in the current run; saturates at all-ones.
- `first_fail_idx`, out, `CNT_W`: `vec_count` value at the first mismatch; 0 if no mismatch has occurred.
- `cov`, out, 4: coverage bitmap, bit index {a,b}. See Configuration.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE on the edge where the compare that brings `vec_count` to `NUM_VECTORS` is registered.
  - DONE→RUN on `start`.
- Entering RUN does the following on the same edge:
  - clears `vec_count`, `err_count`, `first_fail_idx`, `cov` and the delay line;
  - does not capture an `in_valid` that is asserted on that `start` cycle.
- Delay line: `LATENCY` stages of {valid, a, b}. It loads from `in_valid`/`a`/`b` only in RUN. In IDLE/DONE it loads valid=0.
- Compare cycle: the cycle in which the delay-line output valid is 1. With `LATENCY`=0 this is the `in_valid` cycle itself, using the live `a`/`b`.
- Compare rule: expected = {`a`&`b`, `a`^`b`} from the delayed operands, checked against {`carry`, `sum`}.
- Per compare, registered on the next edge:
  - `vec_count`+1;
  - on mismatch: `mismatch`=1 and `err_count`+1 (saturating);
  - if this is the first mismatch: `first_fail_idx`=new `vec_count`.
- Compares arriving after `vec_count` has reached `NUM_VECTORS` are dropped.
- `pass` = (`err_count`==0), gated by `done`. `pass` is 0 outside DONE.
- Reset asserted mid-run aborts immediately. All counters clear and the FSM returns to IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `mismatch`=0, `vec_count`=0, `err_count`=0, `first_fail_idx`=0, `cov`=0.
- Result timing: compare at cycle T; counters and `mismatch` update at edge T+1.
- `done` rises at edge T+1 of the final compare. `pass` is valid in the same cycle.
- End-to-end latency is `LATENCY`+1 cycles from `in_valid` to counter update.
- Back-to-back `in_valid` is supported at one vector per cycle.
- `start` in DONE: counters clear and `done` falls at the next edge.

## Configuration
- Macro `HA_CHECK_COVERAGE_EN`.
- Defined:
  - `cov[{a,b}]` sets on each compare cycle;
  - `pass` additionally requires `cov`==4'b1111.
- Undefined:
  - `cov` is tied to 4'b0000;
  - `pass` depends on `err_count` only;
  - no coverage logic is synthesized.

## Test plan
- Correct adder, `LATENCY`=0, `NUM_VECTORS`=4. Pulse `start`, then apply {a,b} = 00, 01, 10, 11 on consecutive cycles. Required: `done`=1 and `pass`=1 one cycle after the fourth vector; `err_count`=0, `vec_count`=4; `cov`=4'b1111 when the macro is defined.
- Adder with stuck-at-0 `carry`, same stimulus. Required: `mismatch` pulses once, on the 11 vector; `err_count`=1, `first_fail_idx`=4, `pass`=0.
- `LATENCY`=3, results delayed 3 cycles, vectors spaced with idle gaps. Required: zero errors; `done` rises exactly 4 cycles after the last `in_valid`.
- Apply 6 `in_valid` vectors with `NUM_VECTORS`=4. Required: `vec_count` stops at 4, and the extra vectors do not change any counter.
- Assert `rst_n`=0 after 2 vectors. Required: all outputs return to their reset values immediately. A subsequent `start` with a full run yields `pass`=1.
- Macro defined, correct adder, stimulus of 00, 01, 01, 00. Required: `cov`=4'b0011 and `pass`=0 while `err_count`=0.
